// File: rtl/transmit_stream_if.sv
// Valid/ready instruction stream between the transmitter
// and the fetch-side consumer.
interface transmit_stream_if #(
  parameter int IWIDTH = 32
);
  logic [IWIDTH-1:0] t_o_instr;
  logic              t_o_valid;
  logic              t_o_last;
  logic              t_i_ready;

  modport master (
    output t_o_instr,
    output t_o_valid,
    output t_o_last,
    input  t_i_ready
  );

  modport slave (
    input  t_o_instr,
    input  t_o_valid,
    input  t_o_last,
    output t_i_ready
  );
endinterface

// File: rtl/transmit_stream.sv
// DEPTH-entry instruction store streamed to fetch as
// start/length bursts with backpressure and completion ack.
module transmit_stream #(
  parameter int IWIDTH = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH),
  parameter int LW     = 8
) (
  input  logic              t_clk,
  input  logic              t_rst,
  input  logic              t_i_wr_en,
  input  logic [AW-1:0]     t_i_wr_addr,
  input  logic [IWIDTH-1:0] t_i_wr_data,
  input  logic              t_i_syn,
  input  logic [AW-1:0]     t_i_start,
  input  logic [LW-1:0]     t_i_len,
  output logic              t_o_ack,
  output logic              t_o_err,
  output logic              t_o_busy,
  transmit_stream_if.master tx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_ACK
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [LW-1:0]     cnt_q, cnt_d;
  logic [IWIDTH-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              busy_q;

  logic [IWIDTH-1:0] mem_q [DEPTH];

  logic start_ok;
  logic wr_ok;

  // Explicit wrap so non power-of-two depths stay in range
  function automatic logic [AW-1:0] inc(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign start_ok =
    {1'b0, t_i_start} < (AW+1)'(DEPTH);
  assign wr_ok = t_i_wr_en &&
    ({1'b0, t_i_wr_addr} < (AW+1)'(DEPTH));

  // Store is never reset; loads read the pre-write value
  always_ff @(posedge t_clk) begin
    if (wr_ok) mem_q[t_i_wr_addr] <= t_i_wr_data;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    valid_d = valid_q;
    last_d  = last_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (t_i_syn) begin
          if (start_ok) begin
            instr_d = mem_q[t_i_start];
            valid_d = 1'b1;
            last_d  = (t_i_len == '0);
            ptr_d   = inc(t_i_start);
            cnt_d   = t_i_len;
            state_d = S_SEND;
          end else begin
            ack_d   = 1'b1;
            err_d   = 1'b1;
            state_d = S_ACK;
          end
        end
      end
      S_SEND: begin
        if (valid_q && tx.t_i_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            ack_d   = 1'b1;
            state_d = S_ACK;
          end else begin
            instr_d = mem_q[ptr_q];
            ptr_d   = inc(ptr_q);
            cnt_d   = cnt_q - 1'b1;
            last_d  = (cnt_q == LW'(1));
          end
        end
      end
      S_ACK: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge t_clk or posedge t_rst) begin
    if (t_rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign tx.t_o_instr = instr_q;
  assign tx.t_o_valid = valid_q;
  assign tx.t_o_last  = last_q;
  assign t_o_ack      = ack_q;
  assign t_o_err      = err_q;
  assign t_o_busy     = busy_q;

endmodule

// File: tb/tb_transmit_stream.sv
// Directed bench for transmit_stream: scoreboarded bursts on
// a 16-deep instance, reject and odd-depth wrap on a 12-deep one.
module tb_transmit_stream;

  logic        t_clk = 1'b0;
  logic        t_rst;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        syn16, syn12;
  logic [3:0]  start;
  logic [7:0]  len;
  logic        ack16, err16, busy16;
  logic        ack12, err12, busy12;

  always #5 t_clk = ~t_clk;

  transmit_stream_if #(.IWIDTH(32)) s16 ();
  transmit_stream_if #(.IWIDTH(32)) s12 ();

  transmit_stream #(.IWIDTH(32), .DEPTH(16), .LW(8)) u16 (
    .t_clk       (t_clk),
    .t_rst       (t_rst),
    .t_i_wr_en   (wr_en),
    .t_i_wr_addr (wr_addr),
    .t_i_wr_data (wr_data),
    .t_i_syn     (syn16),
    .t_i_start   (start),
    .t_i_len     (len),
    .t_o_ack     (ack16),
    .t_o_err     (err16),
    .t_o_busy    (busy16),
    .tx          (s16)
  );

  transmit_stream #(.IWIDTH(32), .DEPTH(12), .LW(8)) u12 (
    .t_clk       (t_clk),
    .t_rst       (t_rst),
    .t_i_wr_en   (wr_en),
    .t_i_wr_addr (wr_addr),
    .t_i_wr_data (wr_data),
    .t_i_syn     (syn12),
    .t_i_start   (start),
    .t_i_len     (len),
    .t_o_ack     (ack12),
    .t_o_err     (err12),
    .t_o_busy    (busy12),
    .tx          (s12)
  );

  typedef struct {
    logic [31:0] i;
    logic        l;
  } beat_t;

  beat_t       sb[$];
  logic [31:0] m16 [16];
  logic [31:0] m12 [12];
  int          vecs = 0;
  int          errs = 0;
  int          cyc = 0;
  int          beats = 0;
  int          last_cyc = 0;
  logic        hold_p = 1'b0;
  logic [31:0] hold_i;
  logic        hold_l;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  always @(posedge t_clk) cyc <= cyc + 1;

  // Scoreboard and hold-stability monitor for the 16-deep DUT
  always @(negedge t_clk) begin
    if (t_rst) begin
      hold_p = 1'b0;
    end else begin
      if (hold_p) begin
        chk("hold_valid", s16.t_o_valid, 1'b1);
        chk("hold_instr", s16.t_o_instr, hold_i);
        chk("hold_last", s16.t_o_last, hold_l);
      end
      hold_p = s16.t_o_valid && !s16.t_i_ready;
      hold_i = s16.t_o_instr;
      hold_l = s16.t_o_last;
      if (s16.t_o_valid && s16.t_i_ready) begin
        chk("sb_nonempty", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          beat_t e;
          e = sb.pop_front();
          chk("beat_instr", s16.t_o_instr, e.i);
          chk("beat_last", s16.t_o_last, e.l);
          beats++;
          if (s16.t_o_last) last_cyc = cyc;
        end
      end
    end
  end

  task automatic run16(input int st, input int ln,
                       input bit bp);
    bit got;
    int k;
    for (int j = 0; j <= ln; j++)
      sb.push_back('{m16[(st + j) % 16], j == ln});
    beats = 0;
    @(posedge t_clk); #1;
    start = 4'(st);
    len = 8'(ln);
    syn16 = 1'b1;
    s16.t_i_ready = 1'b1;
    @(posedge t_clk); #1;
    syn16 = 1'b0;
    @(negedge t_clk);
    chk("first_valid", s16.t_o_valid, 1'b1);
    chk("busy_send", busy16, 1'b1);
    got = 1'b0;
    k = 0;
    for (int c = 0; c < 400; c++) begin
      if (ack16) begin
        got = 1'b1;
        break;
      end
      @(posedge t_clk); #1;
      k++;
      s16.t_i_ready = bp ? ((k % 4 == 0) || (k % 4 == 3))
                         : 1'b1;
      @(negedge t_clk);
    end
    chk("ack_seen", got, 1'b1);
    chk("ack_lat", cyc, last_cyc + 1);
    chk("err_ok", err16, 1'b0);
    chk("beats", beats, ln + 1);
    chk("sb_empty", sb.size(), 0);
    chk("valid_off", s16.t_o_valid, 1'b0);
    @(negedge t_clk);
    chk("ack_pulse", ack16, 1'b0);
    chk("busy_idle", busy16, 1'b0);
    sb.delete();
  endtask

  initial begin
    t_rst = 1'b1;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    syn16 = 1'b0;
    syn12 = 1'b0;
    start = '0;
    len = '0;
    s16.t_i_ready = 1'b0;
    s12.t_i_ready = 1'b0;
    repeat (2) @(posedge t_clk);
    #1 t_rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      @(posedge t_clk); #1;
      wr_en = 1'b1;
      wr_addr = 4'(i);
      wr_data = 32'hA000_0000 + i;
      m16[i] = 32'hA000_0000 + i;
      if (i < 12) m12[i] = 32'hA000_0000 + i;
    end
    @(posedge t_clk); #1 wr_en = 1'b0;

    // Reset after loading: outputs clear, store survives
    t_rst = 1'b1;
    repeat (2) begin
      @(negedge t_clk);
      chk("rst_instr", s16.t_o_instr, 32'h0);
      chk("rst_valid", s16.t_o_valid, 1'b0);
      chk("rst_last", s16.t_o_last, 1'b0);
      chk("rst_ack", ack16, 1'b0);
      chk("rst_err", err16, 1'b0);
      chk("rst_busy", busy16, 1'b0);
    end
    @(posedge t_clk); #1 t_rst = 1'b0;

    run16(3, 2, 1'b0);
    run16(14, 3, 1'b0);
    run16(5, 6, 1'b1);
    run16(9, 0, 1'b0);
    run16(10, 17, 1'b0);
    run16(0, 9, 1'b1);

    // Rejected request on the 12-deep instance
    @(posedge t_clk); #1;
    start = 4'd13;
    len = 8'd2;
    syn12 = 1'b1;
    @(posedge t_clk); #1 syn12 = 1'b0;
    @(negedge t_clk);
    chk("rej_ack", ack12, 1'b1);
    chk("rej_err", err12, 1'b1);
    chk("rej_busy", busy12, 1'b1);
    chk("rej_valid", s12.t_o_valid, 1'b0);
    @(negedge t_clk);
    chk("rej_ack_off", ack12, 1'b0);
    chk("rej_err_off", err12, 1'b0);
    chk("rej_busy_off", busy12, 1'b0);
    chk("rej_valid_off", s12.t_o_valid, 1'b0);

    // Odd-depth wrap: 11 must advance to 0
    @(posedge t_clk); #1;
    start = 4'd10;
    len = 8'd3;
    syn12 = 1'b1;
    s12.t_i_ready = 1'b1;
    @(posedge t_clk); #1 syn12 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge t_clk);
      chk("w12_valid", s12.t_o_valid, 1'b1);
      chk("w12_instr", s12.t_o_instr, m12[(10 + k) % 12]);
      chk("w12_last", s12.t_o_last, k == 3);
    end
    @(negedge t_clk);
    chk("w12_ack", ack12, 1'b1);
    chk("w12_err", err12, 1'b0);
    chk("w12_valid_off", s12.t_o_valid, 1'b0);

    // Reset mid-burst after two beats of five
    for (int j = 0; j <= 4; j++)
      sb.push_back('{m16[(2 + j) % 16], j == 4});
    beats = 0;
    @(posedge t_clk); #1;
    start = 4'd2;
    len = 8'd4;
    syn16 = 1'b1;
    s16.t_i_ready = 1'b1;
    @(posedge t_clk); #1 syn16 = 1'b0;
    @(posedge t_clk);
    @(posedge t_clk); #1;
    t_rst = 1'b1;
    #1;
    chk("mid_beats", beats, 2);
    chk("mid_instr", s16.t_o_instr, 32'h0);
    chk("mid_valid", s16.t_o_valid, 1'b0);
    chk("mid_last", s16.t_o_last, 1'b0);
    chk("mid_busy", busy16, 1'b0);
    sb.delete();
    repeat (2) begin
      @(negedge t_clk);
      chk("mid_noack", ack16, 1'b0);
    end
    @(posedge t_clk); #1 t_rst = 1'b0;
    @(negedge t_clk);
    chk("post_noack", ack16, 1'b0);
    run16(7, 4, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
